interrupt_controller: RTL and testbench

- Owns the IE (0xFFFF) and IF (0xFF0F) registers, the IME master enable and the EI one-instruction delay.
- Arbitrates the five interrupt sources by fixed priority: bit 0 VBlank is highest, bit 4 Joypad is lowest.
- Sequences dispatch with the ControlUnit: requests dispatch at an instruction boundary, then resolves the winner and its vector at the acknowledge point.
- Provides the wake signal that takes the ControlUnit out of HALT.

---
 rtl/interrupt_controller_if.sv | 37 +++
 rtl/interrupt_controller.sv | 130 +++++++++++++
 tb/tb_interrupt_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_controller_if : CPU-side register/dispatch bus of the IRQ unit |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface interrupt_controller_if;
  logic [7:0]  i_Data;
  logic        i_IE_Write;
  logic        i_IF_Write;
  logic [7:0]  o_IE;
  logic [7:0]  o_IF;
  logic        i_EI;
  logic        i_DI;
  logic        i_RETI;
  logic        i_Fetch_Boundary;
  logic        i_Dispatch_Ack;
  logic        o_Handle_Interrupt;
  logic [15:0] o_Vector;
  logic        o_Vector_Valid;
  logic        o_IME;
  logic        o_Wake;

  modport master (
    output i_Data, i_IE_Write, i_IF_Write, i_EI, i_DI, i_RETI,
           i_Fetch_Boundary, i_Dispatch_Ack,
    input  o_IE, o_IF, o_Handle_Interrupt, o_Vector, o_Vector_Valid,
           o_IME, o_Wake
  );

  modport slave (
    input  i_Data, i_IE_Write, i_IF_Write, i_EI, i_DI, i_RETI,
           i_Fetch_Boundary, i_Dispatch_Ack,
    output o_IE, o_IF, o_Handle_Interrupt, o_Vector, o_Vector_Valid,
           o_IME, o_Wake
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_controller : IE/IF/IME registers, priority arbiter, dispatch   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module interrupt_controller #(
  parameter int          NUM_INT       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  wire logic               i_Clk,
  input  wire logic               i_Rst,
  input  wire logic               i_Enable,
  input  wire logic [NUM_INT-1:0] i_Request,
  interrupt_controller_if.slave   bus
);

  localparam logic [15:0] c_STRIDE = 16'(VECTOR_STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_INT-1:0] if_q, if_d;
  logic               ime_q, ime_d;
  logic [1:0]         ei_cnt_q, ei_cnt_d;
  logic [15:0]        vector_q, vector_d;

  logic [NUM_INT-1:0] pending;
  logic [NUM_INT-1:0] win_mask;
  logic [15:0]        win_idx;
  logic               win_found;

  assign pending = ie_q[NUM_INT-1:0] & if_q;

  // Downward scan so the lowest set bit is the last one to overwrite.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_mask  = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_found   = 1'b1;
        win_idx     = 16'(i);
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    if_d     = if_q;
    ime_d    = ime_q;
    ei_cnt_d = ei_cnt_q;
    vector_d = vector_q;

    if (i_Enable) begin
      if (bus.i_IE_Write) ie_d = bus.i_Data;
      if (bus.i_IF_Write) if_d = bus.i_Data[NUM_INT-1:0];

      case (state_q)
        ST_IDLE: begin
          if (bus.i_DI) begin
            ime_d    = 1'b0;
            ei_cnt_d = 2'd0;
          end else if (bus.i_RETI) begin
            ime_d    = 1'b1;
            ei_cnt_d = 2'd0;
          end else if (bus.i_EI) begin
            ei_cnt_d = 2'd2;
          end else if (bus.i_Fetch_Boundary && ei_cnt_q != 2'd0) begin
            ei_cnt_d = ei_cnt_q - 2'd1;
            if (ei_cnt_q == 2'd1) ime_d = 1'b1;
          end
          // Decision sees the freshly updated IME so a landing EI can dispatch.
          if (bus.i_Fetch_Boundary && ime_d && (|pending)) begin
            state_d  = ST_REQ;
            ime_d    = 1'b0;
            ei_cnt_d = 2'd0;
          end
        end
        ST_REQ: begin
          if (bus.i_Dispatch_Ack) begin
            state_d  = ST_VALID;
            vector_d = win_found ? (VECTOR_BASE + win_idx * c_STRIDE) : 16'h0000;
            if_d     = if_d & ~win_mask;
          end
        end
        ST_VALID: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      if_d = if_d | i_Request;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= ST_IDLE;
      ie_q     <= 8'h00;
      if_q     <= '0;
      ime_q    <= 1'b0;
      ei_cnt_q <= 2'd0;
      vector_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      if_q     <= if_d;
      ime_q    <= ime_d;
      ei_cnt_q <= ei_cnt_d;
      vector_q <= vector_d;
    end
  end

  assign bus.o_IE               = ie_q;
  assign bus.o_IF               = {{(8-NUM_INT){1'b1}}, if_q};
  assign bus.o_IME              = ime_q;
  assign bus.o_Handle_Interrupt = (state_q == ST_REQ);
  assign bus.o_Vector_Valid     = (state_q == ST_VALID);
  assign bus.o_Vector           = vector_q;
  assign bus.o_Wake             = |pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interrupt_controller : directed checks of interrupt_controller        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [4:0] request;
  int         n_checks = 0;
  int         n_pass   = 0;

  interrupt_controller_if ifc ();

  interrupt_controller dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Enable  (enable),
    .i_Request (request),
    .bus       (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable                = 1'b1;
    request               = '0;
    ifc.i_Data            = 8'h00;
    ifc.i_IE_Write        = 1'b0;
    ifc.i_IF_Write        = 1'b0;
    ifc.i_EI              = 1'b0;
    ifc.i_DI              = 1'b0;
    ifc.i_RETI            = 1'b0;
    ifc.i_Fetch_Boundary  = 1'b0;
    ifc.i_Dispatch_Ack    = 1'b0;
  endtask

  task automatic ie_write(input logic [7:0] d);
    ifc.i_Data = d; ifc.i_IE_Write = 1'b1; tick(); ifc.i_IE_Write = 1'b0;
  endtask

  task automatic if_write(input logic [7:0] d);
    ifc.i_Data = d; ifc.i_IF_Write = 1'b1; tick(); ifc.i_IF_Write = 1'b0;
  endtask

  task automatic boundary();
    ifc.i_Fetch_Boundary = 1'b1; tick(); ifc.i_Fetch_Boundary = 1'b0;
  endtask

  task automatic reti();
    ifc.i_RETI = 1'b1; tick(); ifc.i_RETI = 1'b0;
  endtask

  task automatic ack();
    ifc.i_Dispatch_Ack = 1'b1; tick(); ifc.i_Dispatch_Ack = 1'b0;
  endtask

  task automatic dispatch_expect(input string tag, input logic [15:0] vec, input logic [7:0] ifv);
    reti();
    boundary();
    check({tag, "_hi"}, 16'(ifc.o_Handle_Interrupt), 16'd1);
    ack();
    check({tag, "_vec"}, ifc.o_Vector, vec);
    check({tag, "_vv"}, 16'(ifc.o_Vector_Valid), 16'd1);
    check({tag, "_if"}, 16'(ifc.o_IF), 16'(ifv));
    tick();
    check({tag, "_vv_off"}, 16'(ifc.o_Vector_Valid), 16'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // 1: reset values, pending but IME=0
    check("rst_ie",  16'(ifc.o_IE), 16'h00);
    check("rst_if",  16'(ifc.o_IF), 16'hE0);
    check("rst_ime", 16'(ifc.o_IME), 16'd0);
    check("rst_hi",  16'(ifc.o_Handle_Interrupt), 16'd0);
    check("rst_vec", ifc.o_Vector, 16'h0000);
    check("rst_vv",  16'(ifc.o_Vector_Valid), 16'd0);
    check("rst_wake", 16'(ifc.o_Wake), 16'd0);
    ie_write(8'h1F);
    request = 5'b00100; tick(); request = '0;
    check("t1_if",   16'(ifc.o_IF), 16'hE4);
    check("t1_wake", 16'(ifc.o_Wake), 16'd1);
    boundary(); check("t1_hi_a", 16'(ifc.o_Handle_Interrupt), 16'd0);
    boundary(); check("t1_hi_b", 16'(ifc.o_Handle_Interrupt), 16'd0);

    // 2: EI delay, dispatch of source 2
    ifc.i_EI = 1'b1; tick(); ifc.i_EI = 1'b0;
    boundary();
    check("t2_b1_ime", 16'(ifc.o_IME), 16'd0);
    check("t2_b1_hi",  16'(ifc.o_Handle_Interrupt), 16'd0);
    boundary();
    check("t2_b2_hi",  16'(ifc.o_Handle_Interrupt), 16'd1);
    check("t2_b2_ime", 16'(ifc.o_IME), 16'd0);
    tick();
    check("t2_hold_hi", 16'(ifc.o_Handle_Interrupt), 16'd1);
    ack();
    check("t2_vec", ifc.o_Vector, 16'h0050);
    check("t2_vv",  16'(ifc.o_Vector_Valid), 16'd1);
    check("t2_if",  16'(ifc.o_IF), 16'hE0);
    check("t2_hi",  16'(ifc.o_Handle_Interrupt), 16'd0);
    tick();
    check("t2_vv_off",  16'(ifc.o_Vector_Valid), 16'd0);
    check("t2_vec_hold", ifc.o_Vector, 16'h0050);

    // 3: fixed priority across three pending sources
    if_write(8'h13);
    dispatch_expect("t3a", 16'h0040, 8'hF2);
    dispatch_expect("t3b", 16'h0048, 8'hF0);
    dispatch_expect("t3c", 16'h0060, 8'hE0);

    // 4: dispatch cancelled by late IE clear
    if_write(8'h01);
    reti();
    boundary();
    check("t4_hi", 16'(ifc.o_Handle_Interrupt), 16'd1);
    ie_write(8'h00);
    ack();
    check("t4_vec", ifc.o_Vector, 16'h0000);
    check("t4_vv",  16'(ifc.o_Vector_Valid), 16'd1);
    check("t4_if",  16'(ifc.o_IF), 16'hE1);
    tick();
    check("t4_vv_off", 16'(ifc.o_Vector_Valid), 16'd0);

    // 5: request beats write; DI beats EI and clears the delay counter
    ie_write(8'h1F);
    request = 5'b00001; ifc.i_Data = 8'h00; ifc.i_IF_Write = 1'b1;
    tick();
    request = '0; ifc.i_IF_Write = 1'b0;
    check("t5_if", 16'(ifc.o_IF), 16'hE1);
    ifc.i_EI = 1'b1; tick();
    ifc.i_DI = 1'b1; tick();
    ifc.i_EI = 1'b0; ifc.i_DI = 1'b0;
    check("t5_ime", 16'(ifc.o_IME), 16'd0);
    boundary(); boundary();
    check("t5_ime_late", 16'(ifc.o_IME), 16'd0);
    check("t5_hi",       16'(ifc.o_Handle_Interrupt), 16'd0);

    // 6: clock enable low freezes state; reset overrides it
    enable = 1'b0;
    request = 5'b11110; ifc.i_Data = 8'h00;
    ifc.i_IE_Write = 1'b1; ifc.i_IF_Write = 1'b1;
    ifc.i_RETI = 1'b1; ifc.i_Fetch_Boundary = 1'b1;
    tick();
    idle_inputs();
    check("t6_ie",  16'(ifc.o_IE), 16'h1F);
    check("t6_if",  16'(ifc.o_IF), 16'hE1);
    check("t6_ime", 16'(ifc.o_IME), 16'd0);
    check("t6_hi",  16'(ifc.o_Handle_Interrupt), 16'd0);
    reti();
    boundary();
    check("t6_req", 16'(ifc.o_Handle_Interrupt), 16'd1);
    enable = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; enable = 1'b1;
    check("t6_rst_hi",  16'(ifc.o_Handle_Interrupt), 16'd0);
    check("t6_rst_ie",  16'(ifc.o_IE), 16'h00);
    check("t6_rst_if",  16'(ifc.o_IF), 16'hE0);
    check("t6_rst_ime", 16'(ifc.o_IME), 16'd0);
    check("t6_rst_vv",  16'(ifc.o_Vector_Valid), 16'd0);
    check("t6_rst_vec", ifc.o_Vector, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
